// File: rtl/cfa_diag_window_gen.sv
// rtl/cfa_diag_window_gen.sv - diagonal corner window generator for the CFA interpolation datapath
//
// Line-buffers a raster G plane and raw R/B CFA stream and, for every interior
// centre pixel (r-1, c-1), emits the four diagonal corner samples of each plane.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, sof            pixel strobe; sof marks pixel (0,0) when qualified by in_valid
//   G_in, RB_in              G plane sample and raw CFA sample at the current raster position
//   out_valid                one-cycle pulse, window outputs valid
//   G_*_*, RB_*_*            corner samples at (r-1,c-1),(r-1,c+1),(r+1,c-1),(r+1,c+1) of the centre
//   RB_c, c_phase            centre CFA sample and {row[0],col[0]} of the centre
//                            (only when CFA_CENTER_OUT_EN is defined)
//
// Optional feature macro: CFA_CENTER_OUT_EN

module cfa_diag_window_gen #(
  parameter int DataBitWidth = 12,
  parameter int ImageWidth   = 640,
  parameter int ImageHeight  = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    sof,
  input  logic [DataBitWidth-1:0] G_in,
  input  logic [DataBitWidth-1:0] RB_in,
  output logic                    out_valid,
  output logic [DataBitWidth-1:0] G_m1_m1,
  output logic [DataBitWidth-1:0] G_m1_p1,
  output logic [DataBitWidth-1:0] G_p1_m1,
  output logic [DataBitWidth-1:0] G_p1_p1,
  output logic [DataBitWidth-1:0] RB_m1_m1,
  output logic [DataBitWidth-1:0] RB_m1_p1,
  output logic [DataBitWidth-1:0] RB_p1_m1,
  output logic [DataBitWidth-1:0] RB_p1_p1
`ifdef CFA_CENTER_OUT_EN
  ,
  output logic [DataBitWidth-1:0] RB_c,
  output logic [1:0]              c_phase
`endif
);

  localparam int CW = $clog2(ImageWidth);
  localparam int RW = $clog2(ImageHeight);
  localparam logic [CW-1:0] COL_LAST = CW'(ImageWidth - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ImageHeight - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] col_eff;
  logic [RW-1:0] row_eff;
  logic          emit;

  // sof overrides the running counters so the current pixel is always (0,0).
  always_comb begin
    col_eff = sof ? '0 : col;
    row_eff = sof ? '0 : row;
    emit    = in_valid && (row_eff >= ROW_MIN) && (col_eff >= COL_MIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col_eff == COL_LAST) begin
        col <= '0;
        row <= (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
      end else begin
        col <= col_eff + CW'(1);
        row <= row_eff;
      end
    end
  end

  // Line buffers: l1 holds row r-1, l2 holds row r-2, both addressed by column.
  // Contents are never cleared; rows 0 and 1 of each frame refill them before
  // any window that reads them can be emitted.
  logic [DataBitWidth-1:0] g_l1  [ImageWidth];
  logic [DataBitWidth-1:0] g_l2  [ImageWidth];
  logic [DataBitWidth-1:0] rb_l1 [ImageWidth];
  logic [DataBitWidth-1:0] rb_l2 [ImageWidth];
  logic [DataBitWidth-1:0] g_r1, g_r2, rb_r1, rb_r2;

  always_comb begin
    g_r1  = g_l1[col_eff];
    g_r2  = g_l2[col_eff];
    rb_r1 = rb_l1[col_eff];
    rb_r2 = rb_l2[col_eff];
  end

  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      g_l1[col_eff]  <= G_in;
      g_l2[col_eff]  <= g_r1;
      rb_l1[col_eff] <= RB_in;
      rb_l2[col_eff] <= rb_r1;
    end
  end

  // Column shift registers for columns c-1 (suffix 1) and c-2 (suffix 2).
  // The live column c comes straight from the line-buffer reads and the input.
  // Only the top (r-2) and bottom (r) rows feed diagonal corners; the middle
  // row at c-1 is kept only for the optional centre sample.
  logic [DataBitWidth-1:0] g_top1, g_bot1, g_top2, g_bot2;
  logic [DataBitWidth-1:0] rb_top1, rb_bot1, rb_top2, rb_bot2;

  always_ff @(posedge clk) begin
    if (rst) begin
      g_top1  <= '0;
      g_bot1  <= '0;
      g_top2  <= '0;
      g_bot2  <= '0;
      rb_top1 <= '0;
      rb_bot1 <= '0;
      rb_top2 <= '0;
      rb_bot2 <= '0;
    end else if (in_valid) begin
      g_top2  <= g_top1;
      g_bot2  <= g_bot1;
      g_top1  <= g_r2;
      g_bot1  <= G_in;
      rb_top2 <= rb_top1;
      rb_bot2 <= rb_bot1;
      rb_top1 <= rb_r2;
      rb_bot1 <= RB_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      G_m1_m1   <= '0;
      G_m1_p1   <= '0;
      G_p1_m1   <= '0;
      G_p1_p1   <= '0;
      RB_m1_m1  <= '0;
      RB_m1_p1  <= '0;
      RB_p1_m1  <= '0;
      RB_p1_p1  <= '0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        G_m1_m1  <= g_top2;
        G_m1_p1  <= g_r2;
        G_p1_m1  <= g_bot2;
        G_p1_p1  <= G_in;
        RB_m1_m1 <= rb_top2;
        RB_m1_p1 <= rb_r2;
        RB_p1_m1 <= rb_bot2;
        RB_p1_p1 <= RB_in;
      end
    end
  end

`ifdef CFA_CENTER_OUT_EN
  logic [DataBitWidth-1:0] rb_mid1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_mid1 <= '0;
    end else if (in_valid) begin
      rb_mid1 <= rb_r1;
    end
  end

  // Centre is (row-1, col-1), so its parity bits are the inverted current ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      RB_c    <= '0;
      c_phase <= 2'b00;
    end else if (emit) begin
      RB_c    <= rb_mid1;
      c_phase <= {~row_eff[0], ~col_eff[0]};
    end
  end
`endif

endmodule

// File: tb/tb_cfa_diag_window_gen.sv
// tb/tb_cfa_diag_window_gen.sv - self-checking bench for cfa_diag_window_gen

module tb_cfa_diag_window_gen;

  localparam int DW = 12;
  localparam int W  = 8;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          sof;
  logic [DW-1:0] G_in, RB_in;
  logic          out_valid;
  logic [DW-1:0] G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1;
  logic [DW-1:0] RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1;
`ifdef CFA_CENTER_OUT_EN
  logic [DW-1:0] RB_c;
  logic [1:0]    c_phase;
`endif

  cfa_diag_window_gen #(
    .DataBitWidth(DW),
    .ImageWidth  (W),
    .ImageHeight (H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .sof      (sof),
    .G_in     (G_in),
    .RB_in    (RB_in),
    .out_valid(out_valid),
    .G_m1_m1  (G_m1_m1),
    .G_m1_p1  (G_m1_p1),
    .G_p1_m1  (G_p1_m1),
    .G_p1_p1  (G_p1_p1),
    .RB_m1_m1 (RB_m1_m1),
    .RB_m1_p1 (RB_m1_p1),
    .RB_p1_m1 (RB_p1_m1),
    .RB_p1_p1 (RB_p1_p1)
`ifdef CFA_CENTER_OUT_EN
    ,
    .RB_c     (RB_c),
    .c_phase  (c_phase)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a picture of the frame as received, indexed by raster
  // position, plus the expected (held) output registers.
  logic [DW-1:0]   pic_g  [H][W];
  logic [DW-1:0]   pic_rb [H][W];
  int              mrow = 0;
  int              mcol = 0;
  logic            exp_valid = 1'b0;
  logic [8*DW-1:0] exp_win = '0;
  logic [DW-1:0]   exp_rbc = '0;
  logic [1:0]      exp_phase = 2'b00;
  int              dut_pulses = 0;

  task automatic check(input string tag, input logic [8*DW-1:0] obs, input logic [8*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s,
                      input logic [DW-1:0] g, input logic [DW-1:0] rb);
    int rr;
    int cc;
    rst      = r;
    in_valid = v;
    sof      = s;
    G_in     = g;
    RB_in    = rb;
    @(posedge clk);
    #1;
    if (r) begin
      mrow = 0; mcol = 0;
      exp_valid = 1'b0; exp_win = '0; exp_rbc = '0; exp_phase = 2'b00;
    end else if (v) begin
      rr = s ? 0 : mrow;
      cc = s ? 0 : mcol;
      pic_g[rr][cc]  = g;
      pic_rb[rr][cc] = rb;
      exp_valid = (rr >= 2) && (cc >= 2);
      if (exp_valid) begin
        exp_win = {pic_g[rr-2][cc-2], pic_g[rr-2][cc], pic_g[rr][cc-2], pic_g[rr][cc],
                   pic_rb[rr-2][cc-2], pic_rb[rr-2][cc], pic_rb[rr][cc-2], pic_rb[rr][cc]};
        exp_rbc   = pic_rb[rr-1][cc-1];
        exp_phase = {1'((rr - 1) % 2), 1'((cc - 1) % 2)};
      end
      if (cc + 1 == W) begin
        mcol = 0;
        mrow = (rr + 1) % H;
      end else begin
        mcol = cc + 1;
        mrow = rr;
      end
    end else begin
      exp_valid = 1'b0;
    end
    if (out_valid === 1'b1) dut_pulses++;
    check("out_valid", {95'd0, out_valid}, {95'd0, exp_valid});
    check("window", {G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1,
                     RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1}, exp_win);
`ifdef CFA_CENTER_OUT_EN
    check("rb_c", {84'd0, RB_c}, {84'd0, exp_rbc});
    check("c_phase", {94'd0, c_phase}, {94'd0, exp_phase});
`endif
  endtask

  // Sends raster positions start..start+n-1 of a frame; position 0 carries sof.
  // rnd selects random samples instead of the row*16+col pattern; max_gap
  // inserts up to that many idle cycles (with junk data) before each pixel.
  task automatic send_pixels(input int start, input int n, input bit rnd, input int max_gap);
    int p;
    logic [DW-1:0] g, rb;
    for (int i = 0; i < n; i++) begin
      p = start + i;
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap))
          step(1'b0, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom));
      end
      if (rnd) begin
        g  = DW'($urandom);
        rb = DW'($urandom);
      end else begin
        g  = DW'(((p / W) % H) * 16 + (p % W));
        rb = DW'(12'h800 + ((p / W) % H) * 16 + (p % W));
      end
      step(1'b0, 1'b1, (p % (W * H)) == 0, g, rb);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sof = 1'b0; G_in = '0; RB_in = '0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 12'hABC, 12'h123);
    step(1'b0, 1'b0, 1'b0, '0, '0);

    // Basic window with directed values at pixel (2,2)
    dut_pulses = 0;
    send_pixels(0, 2 * W + 3, 1'b0, 0);
    check("basic_valid", {95'd0, out_valid}, 96'd1);
    check("basic_g_m1_m1", {84'd0, G_m1_m1}, 96'h000);
    check("basic_g_m1_p1", {84'd0, G_m1_p1}, 96'h002);
    check("basic_g_p1_m1", {84'd0, G_p1_m1}, 96'h020);
    check("basic_g_p1_p1", {84'd0, G_p1_p1}, 96'h022);
    check("basic_rb_m1_m1", {84'd0, RB_m1_m1}, 96'h800);
    check("basic_rb_p1_p1", {84'd0, RB_p1_p1}, 96'h822);
`ifdef CFA_CENTER_OUT_EN
    check("basic_rb_c", {84'd0, RB_c}, 96'h811);
    check("basic_phase0", {94'd0, c_phase}, 96'd3);
    send_pixels(2 * W + 3, 1, 1'b0, 0);
    check("basic_phase1", {94'd0, c_phase}, 96'd2);
    send_pixels(2 * W + 4, W * H - (2 * W + 4), 1'b0, 0);
`else
    send_pixels(2 * W + 3, W * H - (2 * W + 3), 1'b0, 0);
`endif
    check("frame1_pulses", 96'(dut_pulses), 96'((W - 2) * (H - 2)));

    // Same frame back to back
    dut_pulses = 0;
    send_pixels(0, W * H, 1'b0, 0);
    check("frame2_pulses", 96'(dut_pulses), 96'((W - 2) * (H - 2)));

    // Throttled input with random gaps
    dut_pulses = 0;
    send_pixels(0, W * H, 1'b0, 3);
    check("throttled_pulses", 96'(dut_pulses), 96'((W - 2) * (H - 2)));

    // Random data frames, with and without gaps
    for (int f = 0; f < 3; f++) begin
      dut_pulses = 0;
      send_pixels(0, W * H, 1'b1, f);
      check("random_pulses", 96'(dut_pulses), 96'((W - 2) * (H - 2)));
    end

    // Mid-frame sof at (2,5)
    send_pixels(0, 2 * W + 5, 1'b1, 1);
    dut_pulses = 0;
    send_pixels(0, W * H, 1'b1, 1);
    check("midsof_pulses", 96'(dut_pulses), 96'((W - 2) * (H - 2)));

    // Reset mid-frame at (3,4), then a fresh frame
    send_pixels(0, 3 * W + 4, 1'b1, 0);
    step(1'b1, 1'b1, 1'b0, DW'($urandom), DW'($urandom));
    check("post_reset_valid", {95'd0, out_valid}, 96'd0);
    dut_pulses = 0;
    send_pixels(0, W * H, 1'b0, 1);
    check("post_reset_pulses", 96'(dut_pulses), 96'((W - 2) * (H - 2)));

    // Idle tail: outputs must hold
    repeat (4) step(1'b0, 1'b0, 1'b0, DW'($urandom), DW'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfa_diag_window_gen.md
Name: cfa_diag_window_gen

Overview:
- Streaming neighbourhood generator for the CFA interpolation datapath, sitting on the producer side of the diagonal-neighbour equation stages.
- Accepts two raster-aligned pixel streams: the raw Bayer R/B-site stream and the already-interpolated G plane.
- Line-buffers both streams and emits, for every interior centre pixel, the four diagonal corner samples of each plane in the G_xx_yy / RB_xx_yy form the equation stages consume.

Parameters:
- DataBitWidth, 12, bits per sample on every pixel port.
- ImageWidth, 640, pixels per line (W); W >= 3.
- ImageHeight, 480, lines per frame (H); H >= 3.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input pixel present this cycle; no backpressure.
- sof  input  1  qualified by in_valid; marks this pixel as (row 0, col 0).
- G_in  input  DataBitWidth  interpolated G sample at the current raster position.
- RB_in  input  DataBitWidth  raw CFA sample at the same raster position.
- out_valid  output  1  one-cycle pulse; window outputs are valid.
- G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1  output  DataBitWidth each  G plane at (r-1,c-1), (r-1,c+1), (r+1,c-1), (r+1,c+1) of the centre.
- RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1  output  DataBitWidth each  RB plane at the same four positions.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - Counters col=0, row=0.
  - out_valid=0.
  - All eight window outputs = 0.
  - Window shift registers = 0.
  - Line-buffer RAM contents are not cleared; invalid contents are masked by out_valid gating.
- Counters:
  - Advance only on in_valid.
  - col increments from 0 to W-1, then wraps to 0 and row increments.
  - At (H-1, W-1), both col and row wrap to 0; the next frame is implicitly expected.
- sof:
  - in_valid & sof forces the current pixel to (0,0).
  - Counters become col=1, row=0 after this pixel.
  - This applies even mid-line or mid-frame. Any partially built window is discarded; no output is produced from pre-sof rows.
- Line buffers:
  - Two line delays per plane (4 memories of W x DataBitWidth), read and written at address col.
  - line1 holds the previous row; line2 holds the row before that.
- Window:
  - Per plane, three 3-deep column shift registers (rows r-2, r-1, r), shifted on in_valid.
- Emission on accepted pixel (row, col) with row >= 2 and col >= 2:
  - Centre = (row-1, col-1).
  - m1_m1 = (row-2, col-2); m1_p1 = (row-2, col); p1_m1 = (row, col-2); p1_p1 = (row, col).
- Latency: outputs registered; out_valid=1 exactly one clk after the accepting edge.
- Border handling:
  - Centres on row 0, row H-1, col 0 or col W-1 are never emitted.
  - Emissions per frame = (W-2)*(H-2).
  - Windows never straddle a line wrap; the col >= 2 check covers this.
- Idle cycles:
  - in_valid=0 gives out_valid=0.
  - Window outputs hold their last values, and no state advances.
  - Gaps of any length are legal anywhere.
- Reset mid-frame: behaves as reset. The first frame after reset must begin with sof; pixels before sof are counted from (0,0).
- No arithmetic: samples pass through unmodified; width DataBitWidth throughout.

Optional Feature:
- Macro: CFA_CENTER_OUT_EN.
- When defined:
  - Adds output RB_c (DataBitWidth), the raw CFA sample at the centre (r-1, c-1).
  - Adds output c_phase (2 bits) = {row_centre[0], col_centre[0]}, so downstream can select the R/B/G equation.
  - Both are registered with the same timing as out_valid, reset to 0, and held when not valid.
- When undefined: neither port nor the extra centre register exists; all other behaviour is identical.

Test Plan:
- Basic window:
  - Stimulus: W=8, H=4, continuous in_valid; sof on the first pixel; G_in = row*16+col, RB_in = 0x800+row*16+col.
  - Response: the cycle after pixel (2,2), out_valid=1 with G_m1_m1=0x00, G_m1_p1=0x02, G_p1_m1=0x20, G_p1_p1=0x22, RB_m1_m1=0x800, RB_p1_p1=0x822.
- Frame count:
  - Stimulus: same frame as above, fed twice back to back.
  - Response: exactly 12 out_valid pulses per frame, none during rows 0–1 or cols 0–1, and the second frame's pulses match the first.
- Throttled input:
  - Stimulus: same frame with in_valid toggling 1,0,0,1,… (random gaps).
  - Response: identical output sequence to the basic test; outputs hold during gaps; out_valid never high in a gap-follow cycle without an accepted pixel.
- Mid-frame sof:
  - Stimulus: assert sof at (2,5) of a frame.
  - Response: no out_valid until the new row 2, col 2; the first window uses only post-sof samples.
- Reset mid-frame:
  - Stimulus: assert rst for one cycle at (3,4), then send a fresh frame with sof.
  - Response: out_valid=0 and all outputs 0 the cycle after reset; subsequent outputs match the basic test.
- CFA_CENTER_OUT_EN build:
  - Stimulus: the basic test stimulus.
  - Response: at the first emission, RB_c=0x811 and c_phase=2'b11; at the next emission (centre (1,2)), c_phase=2'b10.
